// File: rtl/lights_decoder.sv
// Receive-side monitor for the three-lamp hazard pattern bus: checks steps, recovers the mode.
// Optional saturating error counter built only when LIGHTS_DEC_ERRCNT_EN is defined.
module lights_decoder #(
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic [2:0]       pat,
  output logic [1:0]       mode,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StLocked
  } state_t;

  // Decisive classes share their low two bits with the mode encoding.
  localparam logic [2:0] ClsCalm    = 3'd0;
  localparam logic [2:0] ClsLeft    = 3'd1;
  localparam logic [2:0] ClsRight   = 3'd2;
  localparam logic [2:0] ClsS1Low   = 3'd3;
  localparam logic [2:0] ClsNone    = 3'd4;
  localparam logic [2:0] ClsIllegal = 3'd5;

  localparam logic [1:0] ModeRight = 2'b10;
  localparam logic [3:0] LockN     = 4'(LOCK_N);

  state_t     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] match_q, match_d;
  logic [1:0] mode_q, mode_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;

  logic       pat_legal;
  logic [2:0] cls;

  always_comb begin
    unique case (pat)
      3'b101, 3'b010, 3'b100, 3'b001: pat_legal = 1'b1;
      default:                        pat_legal = 1'b0;
    endcase
  end

  always_comb begin
    case ({prev_q, pat})
      6'b010_101: cls = ClsCalm;
      6'b010_100: cls = ClsLeft;
      6'b100_001: cls = ClsLeft;
      6'b010_001: cls = ClsRight;
      6'b001_100: cls = ClsRight;
      6'b100_010: cls = ClsRight;
      6'b001_010: cls = ClsS1Low;
      6'b101_010: cls = ClsNone;
      default:    cls = ClsIllegal;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cand_d   = cand_q;
    match_d  = match_q;
    mode_d   = mode_q;
    locked_d = locked_q;
    err_d    = 1'b0;

    if (strobe) begin
      if (!pat_legal) begin
        err_d    = 1'b1;
        locked_d = 1'b0;
        match_d  = '0;
        state_d  = StIdle;
      end else if (state_q == StIdle) begin
        prev_d  = pat;
        state_d = StTrack;
      end else begin
        prev_d = pat;
        case (cls)
          ClsCalm, ClsLeft, ClsRight: begin
            if (cls[1:0] == cand_q) begin
              match_d = (match_q >= LockN) ? LockN : match_q + 4'd1;
            end else begin
              // A new decisive class is a legal mode change, not an error.
              cand_d   = cls[1:0];
              match_d  = 4'd1;
              locked_d = 1'b0;
              state_d  = StTrack;
            end
          end
          ClsS1Low: begin
            if (cand_q == ModeRight) begin
              locked_d = 1'b0;
              match_d  = '0;
              state_d  = StTrack;
            end
          end
          ClsIllegal: begin
            err_d    = 1'b1;
            match_d  = '0;
            locked_d = 1'b0;
            state_d  = StTrack;
          end
          default: ;
        endcase

        if (state_d == StTrack && match_d == LockN) begin
          mode_d   = cand_d;
          locked_d = 1'b1;
          state_d  = StLocked;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      prev_q   <= '0;
      cand_q   <= '0;
      match_q  <= '0;
      mode_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      mode_q   <= mode_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

`ifdef LIGHTS_DEC_ERRCNT_EN
  logic [CNT_W-1:0] err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else if (err_d && (err_count_q != '1)) begin
      err_count_q <= err_count_q + CNT_W'(1);
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

  assign mode   = mode_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule
